// File: rtl/dut_pkg.sv
// Shared definitions for the radar rectangle reader: frame geometry,
// derived index widths, FSM state type and the frame-store pixel function.
package dut_pkg;

  localparam int unsigned IMG_ROWS  = 16;
  localparam int unsigned IMG_COLS  = 16;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned PIX_W     = 8;

  localparam int unsigned ROW_W     = $clog2(IMG_ROWS);
  localparam int unsigned COL_W     = $clog2(IMG_COLS);
  localparam int unsigned CH_W      = $clog2(NUM_CH);
  localparam int unsigned CH_STRIDE = 37;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  // Frame-store contents: (ch*37 + row*IMG_COLS + col) truncated to PIX_W.
  function automatic logic [PIX_W-1:0] pixel_value(
    input logic [CH_W-1:0]  ch,
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    logic [PIX_W-1:0] ch_term;
    logic [PIX_W-1:0] row_term;
    ch_term  = PIX_W'(PIX_W'(ch) * PIX_W'(CH_STRIDE));
    row_term = PIX_W'(PIX_W'(row) * PIX_W'(IMG_COLS));
    return PIX_W'(ch_term + row_term + PIX_W'(col));
  endfunction

endpackage

// File: rtl/dut_pixel_rom.sv
// Read-only frame store with a registered output (one-cycle read latency).
//   clk, rst_n : clock, async active-low reset
//   ch/row/col : read address
//   data       : pixel at the address sampled on the previous edge
module dut_pixel_rom
  import dut_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH_W-1:0]  ch,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [PIX_W-1:0] data
);

  // Contents are a closed-form function, so the "ROM" is pure logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= pixel_value(ch, row, col);
  end

endmodule

// File: rtl/dut.sv
// Rectangle reader: on data_start latches two corners and a channel, then
// streams the enclosed pixels row-major, one per clock, marking the last
// one with data_end.
//   clk, rst_n          : clock, async active-low reset
//   row_idx1/col_idx1   : first corner
//   row_idx2/col_idx2   : second corner
//   channel_num         : channel to read
//   data_start          : request pulse (honoured only in IDLE)
//   data_end            : high with the last pixel
//   pixel_out           : streamed pixel, 0 when no pixel is presented
module dut
  import dut_pkg::*;
#(
  parameter int unsigned IMG_ROWS = dut_pkg::IMG_ROWS,
  parameter int unsigned IMG_COLS = dut_pkg::IMG_COLS,
  parameter int unsigned NUM_CH   = dut_pkg::NUM_CH,
  parameter int unsigned PIX_W    = dut_pkg::PIX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(IMG_ROWS)-1:0] row_idx1,
  input  logic [$clog2(IMG_COLS)-1:0] col_idx1,
  input  logic [$clog2(IMG_ROWS)-1:0] row_idx2,
  input  logic [$clog2(IMG_COLS)-1:0] col_idx2,
  input  logic [$clog2(NUM_CH)-1:0]   channel_num,
  input  logic                        data_start,
  output logic                        data_end,
  output logic [PIX_W-1:0]            pixel_out
);

  localparam int unsigned RW    = $clog2(IMG_ROWS);
  localparam int unsigned CW    = $clog2(IMG_COLS);
  localparam int unsigned CHW   = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(IMG_ROWS * IMG_COLS) + 1;

  state_t           state;
  logic [RW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic [CW-1:0]    cmin_q;
  logic [CW-1:0]    cmax_q;
  logic [CHW-1:0]   ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_cnt_q;
  logic             issuing;
  logic             rom_vld;
  logic             rom_last;
  logic [PIX_W-1:0] rom_data;

  // Corner normalisation and pixel count straight from the inputs, so the
  // walk can be set up on the very edge that accepts the request.
  logic [RW-1:0]    rmin_c, rmax_c;
  logic [CW-1:0]    cmin_c, cmax_c;
  logic [RW:0]      nrows_c;
  logic [CW:0]      ncols_c;
  logic [CNT_W-1:0] total_c;
  logic             issue_last_c;

  always_comb begin
    rmin_c       = (row_idx1 < row_idx2) ? row_idx1 : row_idx2;
    rmax_c       = (row_idx1 < row_idx2) ? row_idx2 : row_idx1;
    cmin_c       = (col_idx1 < col_idx2) ? col_idx1 : col_idx2;
    cmax_c       = (col_idx1 < col_idx2) ? col_idx2 : col_idx1;
    nrows_c      = (RW+1)'(rmax_c - rmin_c) + (RW+1)'(1);
    ncols_c      = (CW+1)'(cmax_c - cmin_c) + (CW+1)'(1);
    total_c      = CNT_W'(CNT_W'(nrows_c) * CNT_W'(ncols_c));
    issue_last_c = issuing && (cnt_q == last_cnt_q);
  end

  dut_pixel_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (ch_q),
    .row   (row_q),
    .col   (col_q),
    .data  (rom_data)
  );

  // FSM, address walk and output pipeline. READ spans address issue plus the
  // ROM drain cycle so that DONE coincides with the data_end cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cmin_q     <= '0;
      cmax_q     <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      last_cnt_q <= '0;
      issuing    <= 1'b0;
      rom_vld    <= 1'b0;
      rom_last   <= 1'b0;
      pixel_out  <= '0;
      data_end   <= 1'b0;
    end else begin
      rom_vld   <= (state == READ) && issuing;
      rom_last  <= (state == READ) && issue_last_c;
      pixel_out <= rom_vld ? rom_data : '0;
      data_end  <= rom_last;
      case (state)
        IDLE: begin
          if (data_start) begin
            row_q      <= rmin_c;
            col_q      <= cmin_c;
            cmin_q     <= cmin_c;
            cmax_q     <= cmax_c;
            ch_q       <= channel_num;
            cnt_q      <= '0;
            last_cnt_q <= total_c - CNT_W'(1);
            issuing    <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          if (issuing) begin
            if (issue_last_c) begin
              issuing <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (col_q == cmax_q) begin
                col_q <= cmin_q;
                row_q <= row_q + RW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
          if (rom_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dut.sv
// Directed self-checking bench for the rectangle reader.
module tb_dut;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_idx1, col_idx1, row_idx2, col_idx2;
  logic [1:0] channel_num;
  logic       data_start;
  logic       data_end;
  logic [7:0] pixel_out;

  int n_tests = 0;
  int n_fail  = 0;

  dut u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_idx1    (row_idx1),
    .col_idx1    (col_idx1),
    .row_idx2    (row_idx2),
    .col_idx2    (col_idx2),
    .channel_num (channel_num),
    .data_start  (data_start),
    .data_end    (data_end),
    .pixel_out   (pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Call at a negedge; the request is sampled on the following posedge.
  task automatic drive_start(input int r1, input int c1, input int r2, input int c2, input int ch);
    row_idx1    = 4'(r1);
    col_idx1    = 4'(c1);
    row_idx2    = 4'(r2);
    col_idx2    = 4'(c2);
    channel_num = 2'(ch);
    data_start  = 1'b1;
    @(posedge clk);
    #1 data_start = 1'b0;
  endtask

  // Follows drive_start; checks latency, every pixel and data_end, then one
  // trailing idle cycle. busy=1 re-pulses data_start with junk corners
  // mid-stream and in the data_end cycle.
  task automatic expect_stream(input int r1, input int c1, input int r2, input int c2,
                               input int ch, input bit busy,
                               output int first, output int last, output int count);
    int rmin, rmax, cmin, cmax, n, k, exp_pix;
    rmin = (r1 < r2) ? r1 : r2;  rmax = (r1 < r2) ? r2 : r1;
    cmin = (c1 < c2) ? c1 : c2;  cmax = (c1 < c2) ? c2 : c1;
    n = (rmax - rmin + 1) * (cmax - cmin + 1);
    k = 0; first = -1; last = -1; count = 0;
    @(negedge clk);
    check("lat0_pix", 32'(pixel_out), 0);
    @(negedge clk);
    check("lat1_pix", 32'(pixel_out), 0);
    check("lat1_end", 32'(data_end), 0);
    for (int r = rmin; r <= rmax; r++) begin
      for (int c = cmin; c <= cmax; c++) begin
        @(negedge clk);
        exp_pix = (ch * 37 + r * 16 + c) % 256;
        check("pix", 32'(pixel_out), 32'(exp_pix));
        check("end", 32'(data_end), (k == n - 1) ? 1 : 0);
        if (k == 0) first = int'(pixel_out);
        last = int'(pixel_out);
        count++;
        if (busy && (k == 2 || k == n - 1)) begin
          row_idx1 = 4'd9; col_idx1 = 4'd9; row_idx2 = 4'd12; col_idx2 = 4'd14;
          channel_num = 2'd3; data_start = 1'b1;
        end else begin
          data_start = 1'b0;
        end
        k++;
      end
    end
    @(negedge clk);
    data_start = 1'b0;
    check("tail_pix", 32'(pixel_out), 0);
    check("tail_end", 32'(data_end), 0);
  endtask

  task automatic idle_check(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check("idle_pix", 32'(pixel_out), 0);
      check("idle_end", 32'(data_end), 0);
    end
  endtask

  int first, last, count;

  initial begin
    rst_n = 1'b0; data_start = 1'b0;
    row_idx1 = '0; col_idx1 = '0; row_idx2 = '0; col_idx2 = '0; channel_num = '0;
    repeat (3) @(negedge clk);
    check("rst_pix", 32'(pixel_out), 0);
    check("rst_end", 32'(data_end), 0);
    rst_n = 1'b1;
    idle_check(2);

    // Single pixel.
    drive_start(1, 1, 1, 1, 0);
    expect_stream(1, 1, 1, 1, 0, 1'b0, first, last, count);
    check("single_val", 32'(first), 17);
    check("single_cnt", 32'(count), 1);

    // Full frame, issued back-to-back in the first IDLE cycle.
    drive_start(0, 0, 15, 15, 0);
    expect_stream(0, 0, 15, 15, 0, 1'b0, first, last, count);
    check("full_first", 32'(first), 0);
    check("full_last",  32'(last), 255);
    check("full_cnt",   32'(count), 256);

    // Swapped corners.
    drive_start(3, 5, 1, 2, 2);
    expect_stream(3, 5, 1, 2, 2, 1'b0, first, last, count);
    check("swap_first", 32'(first), 92);
    check("swap_last",  32'(last), 127);
    check("swap_cnt",   32'(count), 12);

    // Wrap-around of the pixel value.
    drive_start(15, 15, 15, 15, 3);
    expect_stream(15, 15, 15, 15, 3, 1'b0, first, last, count);
    check("wrap_val", 32'(first), 110);

    // Start pulses while busy and during data_end are ignored.
    drive_start(0, 0, 1, 3, 1);
    expect_stream(0, 0, 1, 3, 1, 1'b1, first, last, count);
    check("busy_first", 32'(first), 37);
    check("busy_last",  32'(last), 56);
    check("busy_cnt",   32'(count), 8);
    idle_check(6);

    // Reset during the 5th pixel.
    drive_start(0, 0, 3, 3, 0);
    repeat (2) @(negedge clk);
    repeat (5) @(negedge clk);
    check("pre_rst_pix", 32'(pixel_out), 16);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pix", 32'(pixel_out), 0);
    check("async_rst_end", 32'(data_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(20);

    // Start sampled on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_start(2, 3, 2, 3, 1);
    expect_stream(2, 3, 2, 3, 1, 1'b0, first, last, count);
    check("postrst_val", 32'(first), 72);
    idle_check(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
